// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data memory responder:
//   state_e       - responder FSM states (IDLE / WAIT / RESP)
//   WAIT_CNT_W    - width of the WAIT down-counter (covers WAIT_CYCLES 0..15)
//   addr_is_err() - flags a byte address that is misaligned or beyond storage
// ----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int WAIT_CNT_W = 4;

   // A word access must be 4-byte aligned and must not address any byte
   // above the 2**addr_width word storage.
   function automatic logic addr_is_err(input logic [31:0] addr,
                                        input int unsigned addr_width);
      logic [31:0] hi;
      hi = addr >> (addr_width + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bus between an initiator (master) and the data memory
// responder (slave).
//   req_valid/req_ready, req_we, req_addr (byte), req_wdata, req_be
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The sender holds valid and its payload stable until that edge;
// valid never depends combinationally on ready.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/data_mem_responder_be_word_ram.sv
// ----------------------------------------------------------------------------
// be_word_ram
// 2**ADDR_WIDTH x 32-bit word storage with per-byte write enables.
//   clk_i    - write clock
//   we_i     - write strobe (sampled on rising edge)
//   addr_i   - word address
//   be_i     - byte-lane enables, bit i -> bits 8i+7:8i
//   wdata_i  - write data
//   rdata_o  - combinational read of addr_i
// Contents are deliberately not reset.
// ----------------------------------------------------------------------------
module be_word_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding word memory responder with a fixed response latency of
// WAIT_CYCLES+1 cycles from the acceptance edge.
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   bus         - slave side of data_mem_responder_if
//   dbg_state_o - current FSM state
// Parameters: ADDR_WIDTH (word-address bits), WAIT_CYCLES (0..15).
// ----------------------------------------------------------------------------
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus,
   output state_e               dbg_state_o
);

   localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
      WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_e                 state_q;
   logic [WAIT_CNT_W-1:0]  cnt_q;
   logic                   req_ready_q;
   logic                   rsp_valid_q;
   logic [31:0]            rdata_q;
   logic                   err_q;

   logic                   accept;
   logic                   req_err;
   logic                   ram_we;
   logic [31:0]            ram_rdata;

   // req_ready_q is 1 exactly in IDLE, so it doubles as the IDLE qualifier.
   assign accept  = bus.req_valid && req_ready_q;
   assign req_err = addr_is_err(bus.req_addr, ADDR_WIDTH);
   assign ram_we  = accept && bus.req_we && !req_err;

   be_word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .addr_i  (bus.req_addr[ADDR_WIDTH+1:2]),
      .be_i    (bus.req_be),
      .wdata_i (bus.req_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  req_ready_q <= 1'b0;
                  err_q       <= req_err;
                  // Load data is captured now; later storage or input
                  // changes must not leak into the response.
                  rdata_q     <= (!bus.req_we && !req_err) ? ram_rdata : 32'd0;
                  if (WAIT_CYCLES == 0) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               // Returning to IDLE raises req_ready only after this edge, so
               // the earliest next acceptance is the following edge.
               if (bus.rsp_ready) begin
                  state_q     <= ST_IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rdata_q     <= '0;
                  err_q       <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign dbg_state_o   = state_q;

endmodule
